add64_operand_sequencer: RTL and testbench
==========================================

Name: add64_operand_sequencer

Overview:
- Operand staging and result capture stage wrapped around the combinational 64-bit ripple adder (full_adder_64bit).
- Upstream: accepts operands as narrow beats over a valid/ready stream and assembles 64-bit A and B. Drives them, with carry-in, onto the adder inputs.
- Downstream: waits a fixed settle time for the ripple path, registers sum/cout/overflow, and presents them on a valid/ready result port.

Parameters:
- BEAT_W, 16, input beat width; legal values 8, 16, 32, 64. N_BEATS = 64/BEAT_W.
- SETTLE_CYCLES, 1, cycles the adder inputs are held before capture; must be >= 1.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  upstream beat valid
- in_ready  out  1  block accepts a beat
- in_data  in  BEAT_W  operand beat, least-significant beat first
- in_cin  in  1  carry-in; sampled with the first beat of an operation
- add_a  out  64  to adder a
- add_b  out  64  to adder b
- add_cin  out  1  to adder cin
- add_sum  in  64  from adder sum
- add_cout  in  1  from adder cout
- add_overflow  in  1  from adder overflow
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_sum  out  64  registered sum
- out_cout  out  1  registered carry-out
- out_overflow  out  1  registered signed overflow
- busy  out  1  high in any state other than LOAD_A with beat count 0

Behaviour:
- Clock and reset: one clock, clk. Reset is rst_n, asynchronous assert, active-low.
- Reset values:
  - State LOAD_A; beat counter 0; settle counter 0.
  - add_a, add_b, add_cin = 0.
  - out_sum, out_cout, out_overflow, out_valid = 0; busy = 0.
  - in_ready decodes from state, so it is 1 once reset is released. Upstream must hold in_valid low during reset.
- Transfers: a beat transfers on a rising edge with in_valid && in_ready. Gaps in in_valid are allowed; the counter only advances on a transfer.
- LOAD_A:
  - in_ready = 1.
  - Beat k is written to add_a[k*BEAT_W +: BEAT_W]. Beat 0 also latches in_cin into add_cin.
  - After beat N_BEATS-1: counter clears and the state moves to LOAD_B.
- LOAD_B:
  - in_ready = 1.
  - Beats fill add_b in the same order.
  - After the last beat: settle counter loads SETTLE_CYCLES and the state moves to SETTLE.
- SETTLE:
  - in_ready = 0.
  - add_a, add_b and add_cin are held stable. The counter decrements each cycle.
  - On the edge where the counter reaches 1: add_sum, add_cout and add_overflow are captured into out_*; out_valid is set; the state moves to OUT.
  - Latency: out_valid rises exactly SETTLE_CYCLES cycles after the edge accepting the last B beat.
- OUT:
  - in_ready = 0. out_* and out_valid are held stable while out_ready = 0.
  - On an edge with out_valid && out_ready: out_valid clears and the state moves to LOAD_A. out_sum, out_cout and out_overflow retain their values.
  - A new first beat can be accepted one cycle after the result handshake, never in the same cycle.
- Throughput: 2*N_BEATS + SETTLE_CYCLES + 1 cycles per operation with no stalls.
- Width rules: no arithmetic is performed in this block. Operands are stored verbatim, and out_* are a bit-exact copy of the adder outputs.
- Boundary conditions:
  - in_valid during SETTLE/OUT is ignored, with no data loss on the upstream side.
  - rst_n asserted mid-load, mid-settle or while out_valid is pending: the operation is abandoned, partial operands are cleared and the block returns to its reset values.
  - out_ready high while out_valid = 0 has no effect.

Optional Feature:
- Macro: ACCUMULATE_EN.
- When defined:
  - Adds input port acc_clr (1 bit, after out_overflow in the port list).
  - After a result handshake, the state goes to LOAD_B instead of LOAD_A, with add_a loaded from out_sum. in_cin is then sampled on the first B beat.
  - A pending-clear flag forces the next operation to start in LOAD_A. It is set by reset, or by acc_clr = 1 on any edge. It is cleared on the first A beat.
  - acc_clr does not disturb an operation in progress.
- When undefined: no acc_clr port; every operation loads A and B.

Test Plan:
- BEAT_W=16, SETTLE=1: A=1, B=2, cin=0 (8 back-to-back beats) -> out_sum=3, cout=0, overflow=0; out_valid high exactly 1 cycle after the last B beat.
- A=0xFFFFFFFFFFFFFFFF, B=1, cin=0 -> out_sum=0, cout=1, overflow=0. Same operands with cin=1 -> out_sum=1, cout=1.
- A=0x7FFFFFFFFFFFFFFF, B=1, cin=0 -> out_sum=0x8000000000000000, overflow=1, cout=0.
- Hold out_ready=0 for 5 cycles with in_valid=1 throughout -> out_* and out_valid stable, in_ready=0, no beats consumed. The first next beat is accepted the cycle after the handshake.
- Assert rst_n low after 5 beats of an operation -> all outputs return to reset values. A fresh 8-beat operation A=0x10, B=0x20 -> out_sum=0x30.
- ACCUMULATE_EN: A=10, B=5 -> 15; then B-only 7 -> 22. Pulse acc_clr, then A=100, B=1 -> 101.

Source files
------------

// File: rtl/add64_operand_sequencer.sv
// Operand staging and result capture around an external 64-bit ripple adder.
// Optional accumulate mode (result feeds back as next A) enabled by ACCUMULATE_EN.
`timescale 1ns/1ps
module add64_operand_sequencer #(
    parameter int unsigned BEAT_W        = 16,
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [BEAT_W-1:0] in_data,
    input  logic              in_cin,
    output logic [63:0]       add_a,
    output logic [63:0]       add_b,
    output logic              add_cin,
    input  logic [63:0]       add_sum,
    input  logic              add_cout,
    input  logic              add_overflow,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [63:0]       out_sum,
    output logic              out_cout,
    output logic              out_overflow,
`ifdef ACCUMULATE_EN
    input  logic              acc_clr,
`endif
    output logic              busy
);

    localparam int unsigned N_BEATS = 64 / BEAT_W;
    localparam int unsigned CNT_W   = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;
    localparam int unsigned SET_W   = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(N_BEATS - 1);

    typedef enum logic [1:0] {
        LOAD_A,
        LOAD_B,
        SETTLE,
        OUT
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [SET_W-1:0]   settle_cnt_q, settle_cnt_d;
    logic [63:0]        add_a_d, add_b_d, out_sum_d;
    logic               add_cin_d, out_cout_d, out_overflow_d, out_valid_d;
    logic               in_ready_d, busy_d;
    logic               beat_xfer;
`ifdef ACCUMULATE_EN
    logic               pend_clr_q, pend_clr_d;
    logic               acc_op_q, acc_op_d;
`endif

    assign beat_xfer = in_valid && in_ready;

    // Next-state and next-output decode.
    always_comb begin
        state_d        = state_q;
        beat_cnt_d     = beat_cnt_q;
        settle_cnt_d   = settle_cnt_q;
        add_a_d        = add_a;
        add_b_d        = add_b;
        add_cin_d      = add_cin;
        out_sum_d      = out_sum;
        out_cout_d     = out_cout;
        out_overflow_d = out_overflow;
        out_valid_d    = out_valid;
`ifdef ACCUMULATE_EN
        pend_clr_d     = pend_clr_q;
        acc_op_d       = acc_op_q;
`endif

        unique case (state_q)
            LOAD_A: begin
                if (beat_xfer) begin
                    for (int unsigned k = 0; k < N_BEATS; k++) begin
                        if (beat_cnt_q == CNT_W'(k)) begin
                            add_a_d[k*BEAT_W +: BEAT_W] = in_data;
                        end
                    end
                    if (beat_cnt_q == '0) begin
                        add_cin_d = in_cin;
`ifdef ACCUMULATE_EN
                        pend_clr_d = 1'b0;
                        acc_op_d   = 1'b0;
`endif
                    end
                    if (beat_cnt_q == LAST_BEAT) begin
                        beat_cnt_d = '0;
                        state_d    = LOAD_B;
                    end else begin
                        beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    end
                end
            end

            LOAD_B: begin
                if (beat_xfer) begin
                    for (int unsigned k = 0; k < N_BEATS; k++) begin
                        if (beat_cnt_q == CNT_W'(k)) begin
                            add_b_d[k*BEAT_W +: BEAT_W] = in_data;
                        end
                    end
`ifdef ACCUMULATE_EN
                    // An accumulate operation never saw an A beat, so carry-in rides on B.
                    if (acc_op_q && (beat_cnt_q == '0)) begin
                        add_cin_d = in_cin;
                    end
`endif
                    if (beat_cnt_q == LAST_BEAT) begin
                        beat_cnt_d   = '0;
                        settle_cnt_d = SET_W'(SETTLE_CYCLES);
                        state_d      = SETTLE;
                    end else begin
                        beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    end
                end
            end

            SETTLE: begin
                // Adder inputs stay frozen; capture once the ripple path has had its time.
                settle_cnt_d = settle_cnt_q - SET_W'(1);
                if (settle_cnt_q == SET_W'(1)) begin
                    settle_cnt_d   = '0;
                    out_sum_d      = add_sum;
                    out_cout_d     = add_cout;
                    out_overflow_d = add_overflow;
                    out_valid_d    = 1'b1;
                    state_d        = OUT;
                end
            end

            OUT: begin
                if (out_valid && out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = LOAD_A;
`ifdef ACCUMULATE_EN
                    if (!(pend_clr_q || acc_clr)) begin
                        state_d  = LOAD_B;
                        add_a_d  = out_sum;
                        acc_op_d = 1'b1;
                    end
`endif
                end
            end

            default: begin
                state_d = LOAD_A;
            end
        endcase

`ifdef ACCUMULATE_EN
        if (acc_clr) begin
            pend_clr_d = 1'b1;
        end
`endif

        in_ready_d = (state_d == LOAD_A) || (state_d == LOAD_B);
        busy_d     = !((state_d == LOAD_A) && (beat_cnt_d == '0));
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= LOAD_A;
            beat_cnt_q   <= '0;
            settle_cnt_q <= '0;
            add_a        <= '0;
            add_b        <= '0;
            add_cin      <= 1'b0;
            out_sum      <= '0;
            out_cout     <= 1'b0;
            out_overflow <= 1'b0;
            out_valid    <= 1'b0;
            in_ready     <= 1'b1;
            busy         <= 1'b0;
`ifdef ACCUMULATE_EN
            pend_clr_q   <= 1'b1;
            acc_op_q     <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            beat_cnt_q   <= beat_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            add_a        <= add_a_d;
            add_b        <= add_b_d;
            add_cin      <= add_cin_d;
            out_sum      <= out_sum_d;
            out_cout     <= out_cout_d;
            out_overflow <= out_overflow_d;
            out_valid    <= out_valid_d;
            in_ready     <= in_ready_d;
            busy         <= busy_d;
`ifdef ACCUMULATE_EN
            pend_clr_q   <= pend_clr_d;
            acc_op_q     <= acc_op_d;
`endif
        end
    end

endmodule

// File: tb/tb_add64_operand_sequencer.sv
// Directed bench for add64_operand_sequencer: behavioural adder, vector table and
// hand-written stall / reset / accumulate sequences.
`timescale 1ns/1ps
module tb_add64_operand_sequencer;

    localparam int unsigned BEAT_W  = 16;
    localparam int unsigned SETTLE  = 1;
    localparam int unsigned N_BEATS = 64 / BEAT_W;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [BEAT_W-1:0] in_data;
    logic              in_cin;
    logic [63:0]       add_a, add_b, add_sum;
    logic              add_cin, add_cout, add_overflow;
    logic              out_valid, out_ready;
    logic [63:0]       out_sum;
    logic              out_cout, out_overflow;
    logic              busy;
`ifdef ACCUMULATE_EN
    logic              acc_clr;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Behavioural stand-in for the external ripple adder.
    logic [64:0] wide_sum;
    assign wide_sum     = {1'b0, add_a} + {1'b0, add_b} + {64'b0, add_cin};
    assign add_sum      = wide_sum[63:0];
    assign add_cout     = wide_sum[64];
    assign add_overflow = (add_a[63] == add_b[63]) && (wide_sum[63] != add_a[63]);

    add64_operand_sequencer #(
        .BEAT_W        (BEAT_W),
        .SETTLE_CYCLES (SETTLE)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_cin       (in_cin),
        .add_a        (add_a),
        .add_b        (add_b),
        .add_cin      (add_cin),
        .add_sum      (add_sum),
        .add_cout     (add_cout),
        .add_overflow (add_overflow),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_sum      (out_sum),
        .out_cout     (out_cout),
        .out_overflow (out_overflow),
`ifdef ACCUMULATE_EN
        .acc_clr      (acc_clr),
`endif
        .busy         (busy)
    );

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        cin;
        logic [63:0] exp_sum;
        logic        exp_cout;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Offer one beat and wait (bounded) until the edge that accepts it.
    task automatic send_beat(input logic [BEAT_W-1:0] d, input logic c);
        logic acc;
        int   t;
        in_valid = 1'b1;
        in_data  = d;
        in_cin   = c;
        t        = 0;
        do begin
            acc = in_ready;
            @(posedge clk);
            #1;
            t++;
        end while (!acc && t < 20);
        in_valid = 1'b0;
        in_cin   = 1'b0;
        if (!acc) begin
            n_checks++;
            n_fail++;
            $display("FAIL beat_accept: got no in_ready within %0d cycles, expected acceptance", t);
        end
    endtask

    task automatic send_word(input logic [63:0] w, input logic c, input int first);
        for (int k = first; k < N_BEATS; k++) begin
            send_beat(w[k*BEAT_W +: BEAT_W], (k == 0) ? c : 1'b0);
        end
    endtask

    // Called right after the last B beat is accepted.
    task automatic wait_result(input string name, input logic [63:0] es, input logic ec, input logic eo);
        int n;
        check({name, "_settle_in_ready"}, 64'(in_ready), 64'(0));
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({name, "_latency"}, 64'(n), 64'(SETTLE));
        check({name, "_sum"}, out_sum, es);
        check({name, "_cout"}, 64'(out_cout), 64'(ec));
        check({name, "_ovf"}, 64'(out_overflow), 64'(eo));
    endtask

    task automatic handshake(input string name, input logic clr, input logic [63:0] es);
`ifdef ACCUMULATE_EN
        acc_clr = clr;
`endif
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
`ifdef ACCUMULATE_EN
        acc_clr = 1'b0;
`endif
        check({name, "_hs_valid_clear"}, 64'(out_valid), 64'(0));
        check({name, "_hs_sum_kept"}, out_sum, es);
        check({name, "_hs_in_ready"}, 64'(in_ready), 64'(clr ? 1 : 1));
    endtask

    task automatic full_op(input string name, input logic [63:0] a, input logic [63:0] b, input logic c,
                           input logic [63:0] es, input logic ec, input logic eo);
        send_word(a, c, 0);
        send_word(b, 1'b0, 0);
        wait_result(name, es, ec, eo);
        handshake(name, 1'b1, es);
    endtask

    initial begin
        vecs[0] = '{64'h1, 64'h2, 1'b0, 64'h3, 1'b0, 1'b0};
        vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1, 1'b0};
        vecs[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b1, 64'h1, 1'b1, 1'b0};
        vecs[3] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
        vecs[4] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'h0, 1'b1, 1'b1};
        vecs[5] = '{64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1,
                    64'h2222_2222_2222_2212, 1'b0, 1'b0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_cin    = 1'b0;
        out_ready = 1'b0;
`ifdef ACCUMULATE_EN
        acc_clr   = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #4 rst_n = 1'b1;
        @(posedge clk);
        #1;

        check("rst_add_a", add_a, 64'h0);
        check("rst_add_b", add_b, 64'h0);
        check("rst_add_cin", 64'(add_cin), 64'(0));
        check("rst_out_sum", out_sum, 64'h0);
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_in_ready", 64'(in_ready), 64'(1));

        // out_ready with nothing pending must be inert.
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("idle_ready_valid", 64'(out_valid), 64'(0));
        check("idle_ready_busy", 64'(busy), 64'(0));

        for (int i = 0; i < 6; i++) begin
            full_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin,
                    vecs[i].exp_sum, vecs[i].exp_cout, vecs[i].exp_ovf);
        end

        // Result stall with upstream pushing; the pushed beat is beat 0 of the next op.
        send_word(64'hFFFF_0000_FFFF_0000, 1'b0, 0);
        send_word(64'h0000_FFFF_0000_FFFF, 1'b0, 0);
        wait_result("stall_op", 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
        in_valid = 1'b1;
        in_data  = 16'h0005;
        in_cin   = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("stall%0d_valid", i), 64'(out_valid), 64'(1));
            check($sformatf("stall%0d_in_ready", i), 64'(in_ready), 64'(0));
            check($sformatf("stall%0d_sum", i), out_sum, 64'hFFFF_FFFF_FFFF_FFFF);
        end
`ifdef ACCUMULATE_EN
        acc_clr = 1'b1;
`endif
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
`ifdef ACCUMULATE_EN
        acc_clr = 1'b0;
`endif
        check("stall_hs_valid", 64'(out_valid), 64'(0));
        check("stall_hs_no_beat", 64'(busy), 64'(0));
        check("stall_hs_in_ready", 64'(in_ready), 64'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("stall_next_beat_busy", 64'(busy), 64'(1));
        check("stall_next_beat_data", 64'(add_a[15:0]), 64'(16'h0005));
        send_word(64'h5, 1'b0, 1);
        send_word(64'h6, 1'b0, 0);
        wait_result("after_stall", 64'hB, 1'b0, 1'b0);
        handshake("after_stall", 1'b1, 64'hB);

        // Reset in the middle of a load: 4 A beats plus 1 B beat.
        send_word(64'h1111_2222_3333_4444, 1'b1, 0);
        send_beat(16'hABCD, 1'b0);
        rst_n = 1'b0;
        #1;
        check("midrst_add_a", add_a, 64'h0);
        check("midrst_add_b", add_b, 64'h0);
        check("midrst_add_cin", 64'(add_cin), 64'(0));
        check("midrst_out_sum", out_sum, 64'h0);
        check("midrst_busy", 64'(busy), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        full_op("post_rst", 64'h10, 64'h20, 1'b0, 64'h30, 1'b0, 1'b0);

`ifdef ACCUMULATE_EN
        send_word(64'd10, 1'b0, 0);
        send_word(64'd5, 1'b0, 0);
        wait_result("acc0", 64'd15, 1'b0, 1'b0);
        handshake("acc0", 1'b0, 64'd15);
        check("acc0_feedback_a", add_a, 64'd15);
        check("acc0_busy", 64'(busy), 64'(1));
        send_word(64'd7, 1'b0, 0);
        wait_result("acc1", 64'd22, 1'b0, 1'b0);
        handshake("acc1", 1'b1, 64'd22);
        check("acc1_cleared_busy", 64'(busy), 64'(0));
        full_op("acc_clr", 64'd100, 64'd1, 1'b0, 64'd101, 1'b0, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by %0t, expected end of test", $time);
        $fatal(1, "timeout");
    end

endmodule
